// File: rtl/mac_operand_seq.sv
// Operand-pair buffer and sequencer feeding the MAC accumulator stage.
// Optional MAC_SEQ_LOOP_EN adds a `loop` input that repeats the programmed pass.
//
// state  | meaning
// IDLE   | buffer writable, waiting for start
// CLEAR  | one-cycle accumulator clear to the MAC
// STREAM | presenting buffer[idx] under valid/ready
// FIN    | one-cycle done pulse, then IDLE (or CLEAR when looping)
module mac_operand_seq #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mac_clr,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic [DATA_W-1:0] mac_a,
    output logic [DATA_W-1:0] mac_b
`ifdef MAC_SEQ_LOOP_EN
    ,
    input  logic              loop
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        STREAM = 2'd2,
        FIN    = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              mac_clr_q, mac_clr_d;
    logic              mac_valid_q, mac_valid_d;
    logic [DATA_W-1:0] mac_a_q, mac_a_d;
    logic [DATA_W-1:0] mac_b_q, mac_b_d;

    logic [DATA_W-1:0] mem_a_q [DEPTH];
    logic [DATA_W-1:0] mem_b_q [DEPTH];
    logic [DATA_W-1:0] mem_a_d [DEPTH];
    logic [DATA_W-1:0] mem_b_d [DEPTH];

    logic len_ok;
    logic last_pair;
    logic loop_sel;

`ifdef MAC_SEQ_LOOP_EN
    assign loop_sel = loop;
`else
    assign loop_sel = 1'b0;
`endif

    assign len_ok    = (len != '0) && (len <= LEN_MAX);
    assign last_pair = ({1'b0, idx_q} == (len_q - LEN_ONE));

    // Buffer is writable only while idle; a same-cycle start sees the new entry.
    always_comb begin
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        if (wr_en && (state_q == IDLE)) begin
            mem_a_d[wr_addr] = wr_a;
            mem_b_d[wr_addr] = wr_b;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d   = len;
                        idx_d   = '0;
                        state_d = CLEAR;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEAR: state_d = STREAM;
            STREAM: begin
                if (mac_ready) begin
                    if (last_pair) state_d = FIN;
                    else           idx_d   = idx_q + IDX_ONE;
                end
            end
            FIN: begin
                idx_d   = '0;
                state_d = loop_sel ? CLEAR : IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (wr_en && busy_q) err_d = 1'b1;

        // Outputs are registered, so they are decoded from the upcoming state.
        busy_d      = (state_d == CLEAR) || (state_d == STREAM) ||
                      ((state_d == FIN) && loop_sel);
        done_d      = (state_d == FIN);
        mac_clr_d   = (state_d == CLEAR);
        mac_valid_d = (state_d == STREAM);
        mac_a_d     = mac_valid_d ? mem_a_q[idx_d] : '0;
        mac_b_d     = mac_valid_d ? mem_b_q[idx_d] : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            len_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mac_clr_q   <= 1'b0;
            mac_valid_q <= 1'b0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mac_clr_q   <= mac_clr_d;
            mac_valid_q <= mac_valid_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
        end
    end

    // Buffer contents deliberately survive reset.
    always_ff @(posedge clk) begin
        mem_a_q <= mem_a_d;
        mem_b_q <= mem_b_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign mac_clr   = mac_clr_q;
    assign mac_valid = mac_valid_q;
    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;

endmodule

// File: tb/tb_mac_operand_seq.sv
// Directed self-checking bench for mac_operand_seq with a small MAC sum model.
module tb_mac_operand_seq;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] wr_addr = '0;
    logic [DATA_W-1:0] wr_a = '0;
    logic [DATA_W-1:0] wr_b = '0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, err, mac_clr, mac_valid;
    logic              mac_ready = 1'b1;
    logic [DATA_W-1:0] mac_a, mac_b;
    logic              loop = 1'b0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    mac_operand_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_a(wr_a), .wr_b(wr_b),
        .start(start), .len(len),
        .busy(busy), .done(done), .err(err),
        .mac_clr(mac_clr), .mac_valid(mac_valid), .mac_ready(mac_ready),
        .mac_a(mac_a), .mac_b(mac_b)
`ifdef MAC_SEQ_LOOP_EN
        , .loop(loop)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if ({busy, done, err, mac_clr, mac_valid} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {busy, done, err, mac_clr, mac_valid});
        end
        checks++;
        if ({mac_a, mac_b} !== 16'h0) begin
            failures++;
            $display("FAIL reset_operands got=%h exp=0000", {mac_a, mac_b});
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, mac_valid} !== 2'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=00", {busy, mac_valid});
        end
    endtask

    task automatic test_basic();
        int sum;
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_a = DATA_W'(i); wr_b = DATA_W'(i);
            tick();
        end
        wr_addr = ADDR_W'(9); wr_a = 8'd9; wr_b = 8'd9;
        start = 1'b1; len = 5'd10;
        tick();
        wr_en = 1'b0; start = 1'b0;
        checks++;
        if ({mac_clr, busy, mac_valid} !== 3'b110) begin
            failures++;
            $display("FAIL basic_clear got=%b exp=110", {mac_clr, busy, mac_valid});
        end
        sum = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({mac_valid, busy, mac_a, mac_b} !== {2'b11, DATA_W'(k), DATA_W'(k)}) begin
                failures++;
                $display("FAIL basic_pair%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, mac_valid, mac_a, mac_b, k, k);
            end
            if (mac_valid && mac_ready) sum += int'(mac_a) * int'(mac_b);
        end
        tick();
        checks++;
        if ({done, busy, mac_valid, mac_a, mac_b} !== {3'b100, 16'h0}) begin
            failures++;
            $display("FAIL basic_done got=%b/%0d/%0d exp=100/0/0", {done, busy, mac_valid}, mac_a, mac_b);
        end
        checks++;
        if (sum !== 285) begin
            failures++;
            $display("FAIL basic_sum got=%0d exp=285", sum);
        end
        tick();
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL basic_idle got=%b exp=00", {done, busy});
        end
    endtask

    task automatic test_stall();
        int sum, k, stall, held3, cycles;
        start = 1'b1; len = 5'd10;
        tick();
        start = 1'b0;
        checks++;
        if (mac_clr !== 1'b1) begin
            failures++;
            $display("FAIL stall_clear got=%b exp=1", mac_clr);
        end
        sum = 0; k = 0; stall = 0; held3 = 0; cycles = 0;
        while (k < 10 && cycles < 40) begin
            tick();
            cycles++;
            checks++;
            if ({mac_valid, mac_a, mac_b} !== {1'b1, DATA_W'(k), DATA_W'(k)}) begin
                failures++;
                $display("FAIL stall_pair%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, mac_valid, mac_a, mac_b, k, k);
            end
            if (k == 3) held3++;
            if (k == 3 && stall < 4) begin
                mac_ready = 1'b0;
                stall++;
            end else begin
                mac_ready = 1'b1;
                if (mac_valid) sum += int'(mac_a) * int'(mac_b);
                k++;
            end
        end
        mac_ready = 1'b1;
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL stall_done got=%b exp=1", done);
        end
        checks++;
        if (cycles !== 14) begin
            failures++;
            $display("FAIL stall_cycles got=%0d exp=14", cycles);
        end
        checks++;
        if (held3 !== 5) begin
            failures++;
            $display("FAIL stall_held got=%0d exp=5", held3);
        end
        checks++;
        if (sum !== 285) begin
            failures++;
            $display("FAIL stall_sum got=%0d exp=285", sum);
        end
        tick();
    endtask

    task automatic test_err_len();
        logic [ADDR_W:0] bad_lens [2];
        bad_lens[0] = 5'd0;
        bad_lens[1] = 5'd17;
        for (int i = 0; i < 2; i++) begin
            start = 1'b1; len = bad_lens[i];
            tick();
            start = 1'b0;
            checks++;
            if ({err, busy, mac_clr, mac_valid} !== 4'b1000) begin
                failures++;
                $display("FAIL errlen%0d_pulse got=%b exp=1000", bad_lens[i], {err, busy, mac_clr, mac_valid});
            end
            tick();
            checks++;
            if ({err, busy, mac_clr, mac_valid} !== 4'b0000) begin
                failures++;
                $display("FAIL errlen%0d_after got=%b exp=0000", bad_lens[i], {err, busy, mac_clr, mac_valid});
            end
        end
    endtask

    task automatic test_busy_write();
        int sum;
        start = 1'b1; len = 5'd10;
        tick();
        start = 1'b0;
        sum = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({mac_valid, mac_a, mac_b} !== {1'b1, DATA_W'(k), DATA_W'(k)}) begin
                failures++;
                $display("FAIL bw_pair%0d got=%b/%0d/%0d exp=1/%0d/%0d", k, mac_valid, mac_a, mac_b, k, k);
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (err !== (k == 3)) begin
                    failures++;
                    $display("FAIL bw_err_k%0d got=%b exp=%b", k, err, (k == 3));
                end
            end
            if (mac_valid && mac_ready) sum += int'(mac_a) * int'(mac_b);
            wr_en = (k == 2); start = (k == 2);
            wr_addr = ADDR_W'(5); wr_a = 8'd99; wr_b = 8'd99;
        end
        tick();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL bw_done got=%b exp=1", done);
        end
        checks++;
        if (sum !== 285) begin
            failures++;
            $display("FAIL bw_sum got=%0d exp=285", sum);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int sum, done_seen;
        start = 1'b1; len = 5'd10;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if ({mac_valid, mac_a} !== {1'b1, 8'd4}) begin
            failures++;
            $display("FAIL rm_pair4 got=%b/%0d exp=1/4", mac_valid, mac_a);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({mac_valid, busy, mac_clr, done, mac_a, mac_b} !== 20'h0) begin
            failures++;
            $display("FAIL rm_async got=%b/%0d/%0d exp=0000/0/0", {mac_valid, busy, mac_clr, done}, mac_a, mac_b);
        end
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done || busy) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin
            failures++;
            $display("FAIL rm_no_done got=%0d exp=0", done_seen);
        end
        start = 1'b1; len = 5'd10;
        tick();
        start = 1'b0;
        sum = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (mac_valid && mac_ready) sum += int'(mac_a) * int'(mac_b);
        end
        tick();
        checks++;
        if ({done, sum} !== {1'b1, 32'd285}) begin
            failures++;
            $display("FAIL rm_rerun got=%b/%0d exp=1/285", done, sum);
        end
        tick();
    endtask

`ifdef MAC_SEQ_LOOP_EN
    task automatic test_loop();
        int last_done;
        for (int i = 0; i < 3; i++) begin
            wr_en = 1'b1; wr_addr = ADDR_W'(i); wr_a = 8'd2; wr_b = 8'd2;
            tick();
        end
        wr_en = 1'b0;
        loop = 1'b1; start = 1'b1; len = 5'd3;
        tick();
        start = 1'b0;
        last_done = 0;
        for (int p = 0; p < 3; p++) begin
            checks++;
            if ({mac_clr, busy} !== 2'b11) begin
                failures++;
                $display("FAIL loop_clear%0d got=%b exp=11", p, {mac_clr, busy});
            end
            for (int j = 0; j < 3; j++) begin
                tick();
                checks++;
                if ({mac_valid, mac_a, mac_b} !== {1'b1, 8'd2, 8'd2}) begin
                    failures++;
                    $display("FAIL loop_pair%0d_%0d got=%b/%0d/%0d exp=1/2/2", p, j, mac_valid, mac_a, mac_b);
                end
                if (p == 2 && j == 0) loop = 1'b0;
            end
            tick();
            checks++;
            if ({done, busy} !== {1'b1, (p < 2)}) begin
                failures++;
                $display("FAIL loop_fin%0d got=%b exp=1%b", p, {done, busy}, (p < 2));
            end
            if (p > 0) begin
                checks++;
                if (cyc - last_done !== 5) begin
                    failures++;
                    $display("FAIL loop_period%0d got=%0d exp=5", p, cyc - last_done);
                end
            end
            last_done = cyc;
            tick();
        end
        checks++;
        if ({busy, mac_clr, done, mac_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL loop_exit got=%b exp=0000", {busy, mac_clr, done, mac_valid});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_err_len();
        test_busy_write();
        test_reset_mid();
`ifdef MAC_SEQ_LOOP_EN
        test_loop();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
